// File: rtl/tlb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tlb_pkg
// Description : Shared TLB definitions. Holds the PTW arbiter state encoding
//               and the default VPN / PTE widths.
// Revision    : 1.0 - initial release
// ============================================================================
package tlb_pkg;

  localparam int VPN_W = 20;
  localparam int PTE_W = 32;

  // 3-bit state encoding of the PTW arbiter.
  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ISSUE = 3'd1,
    ARB_WAIT  = 3'd2,
    ARB_RESP  = 3'd3,
    ARB_DRAIN = 3'd4
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ptw_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arbiter_if
// Description : Bus bundle between the TLB requesters, the PTW arbiter and the
//               page-table walker.
//   slave  modport : arbiter side (drives grants, responses, walker request).
//   master modport : requester + walker side.
//   req_*      : per-requester walk request (valid / packed VPN / ready)
//   resp_*     : per-requester response (one-hot valid / ready, shared PTE,
//                fault)
//   ptw_req_*  : single request channel to the walker
//   ptw_resp_* : single response channel from the walker
//   owner_o / busy_o / timeout_o : status
// Revision    : 1.0 - initial release
// ============================================================================
interface ptw_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int VPN_W   = tlb_pkg::VPN_W,
  parameter int PTE_W   = tlb_pkg::PTE_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*VPN_W-1:0] req_vpn_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [NUM_REQ-1:0]       resp_ready_i;
  logic [PTE_W-1:0]         resp_pte_o;
  logic                     resp_fault_o;
  logic                     ptw_req_valid_o;
  logic                     ptw_req_ready_i;
  logic [VPN_W-1:0]         ptw_req_vpn_o;
  logic                     ptw_resp_valid_i;
  logic                     ptw_resp_ready_o;
  logic [PTE_W-1:0]         ptw_resp_pte_i;
  logic                     ptw_resp_fault_i;
  logic [IDX_W-1:0]         owner_o;
  logic                     busy_o;
  logic                     timeout_o;

  modport slave (
    input  req_valid_i, req_vpn_i, resp_ready_i, ptw_req_ready_i,
           ptw_resp_valid_i, ptw_resp_pte_i, ptw_resp_fault_i,
    output req_ready_o, resp_valid_o, resp_pte_o, resp_fault_o,
           ptw_req_valid_o, ptw_req_vpn_o, ptw_resp_ready_o,
           owner_o, busy_o, timeout_o
  );

  modport master (
    output req_valid_i, req_vpn_i, resp_ready_i, ptw_req_ready_i,
           ptw_resp_valid_i, ptw_resp_pte_i, ptw_resp_fault_i,
    input  req_ready_o, resp_valid_o, resp_pte_o, resp_fault_o,
           ptw_req_valid_o, ptw_req_vpn_o, ptw_resp_ready_o,
           owner_o, busy_o, timeout_o
  );

endinterface
`default_nettype wire

// File: rtl/ptw_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Searches req starting at
//               last_grant+1 (mod NUM_REQ) and returns the first set bit.
//   req        in  NUM_REQ : request vector
//   last_grant in  IDX_W   : index granted most recently
//   grant      out NUM_REQ : one-hot winner (zero when no request)
//   grant_idx  out IDX_W   : winner index (zero when no request)
//   any        out 1       : at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  // One extra bit so last_grant + k (k <= NUM_REQ) cannot overflow before the
  // single conditional subtraction folds it back into range.
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!any && req[w_idx]) begin
        any       = 1'b1;
        grant_idx = w_idx;
      end
    end
    if (any) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ptw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ptw_arbiter
// Description : Shares one page-table walker between NUM_REQ TLB controllers.
//               Round-robin grant, one walk in flight, response routed back
//               to the issuing requester, watchdog forces a fault when the
//               walker is silent for TIMEOUT cycles (0 disables it). A walker
//               response that arrives after a forced fault is absorbed.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ptw_arbiter_if.slave (requester, response, walker, status)
// Revision    : 1.0 - initial release
// ============================================================================
module ptw_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int VPN_W   = tlb_pkg::VPN_W,
  parameter int PTE_W   = tlb_pkg::PTE_W,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          rst,
  ptw_arbiter_if.slave  bus
);
  import tlb_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit               c_wdog_en  = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TMR_W-1:0] c_tmr_max  = TMR_W'(TIMEOUT);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [IDX_W-1:0]  r_last_grant;
  logic [IDX_W-1:0]  r_owner;
  logic [VPN_W-1:0]  r_vpn;
  logic [PTE_W-1:0]  r_pte;
  logic              r_fault;
  logic              r_stale;
  logic              r_timeout;
  logic [TMR_W-1:0]  r_timer;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_req_hs;
  logic               w_tmo_fire;
  logic [NUM_REQ-1:0] w_resp_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid_i),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any        (w_any)
  );

  // Next-state and combinational decode.
  always_comb begin
    w_state_next = r_state;
    w_req_hs     = 1'b0;
    w_tmo_fire   = 1'b0;
    w_resp_valid = '0;
    case (r_state)
      ARB_IDLE: begin
        // Grant only goes to a valid requester, so any request is a handshake.
        if (w_any) begin
          w_req_hs     = 1'b1;
          w_state_next = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.ptw_req_ready_i) begin
          w_state_next = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A response in the final timer cycle takes priority over the fault.
        if (bus.ptw_resp_valid_i) begin
          w_state_next = ARB_RESP;
        end else if (c_wdog_en && (r_timer == c_tmr_last)) begin
          w_tmo_fire   = 1'b1;
          w_state_next = ARB_RESP;
        end
      end
      ARB_RESP: begin
        w_resp_valid[r_owner] = 1'b1;
        if (bus.resp_ready_i[r_owner]) begin
          w_state_next = r_stale ? ARB_DRAIN : ARB_IDLE;
        end
      end
      ARB_DRAIN: begin
        if (bus.ptw_resp_valid_i) begin
          w_state_next = ARB_IDLE;
        end
      end
      default: w_state_next = ARB_IDLE;
    endcase
  end

  // State register and datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_vpn        <= '0;
      r_pte        <= '0;
      r_fault      <= 1'b0;
      r_stale      <= 1'b0;
      r_timeout    <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_state   <= w_state_next;
      r_timeout <= w_tmo_fire;
      case (r_state)
        ARB_IDLE: begin
          if (w_req_hs) begin
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_vpn        <= bus.req_vpn_i[w_grant_idx*VPN_W +: VPN_W];
          end
        end
        ARB_ISSUE: begin
          if (bus.ptw_req_ready_i) begin
            r_timer <= '0;
          end
        end
        ARB_WAIT: begin
          if (bus.ptw_resp_valid_i) begin
            r_pte   <= bus.ptw_resp_pte_i;
            r_fault <= bus.ptw_resp_fault_i;
          end else if (w_tmo_fire) begin
            r_pte   <= '0;
            r_fault <= 1'b1;
            r_stale <= 1'b1;
          end else if (r_timer != c_tmr_max) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ARB_DRAIN: begin
          if (bus.ptw_resp_valid_i) begin
            r_stale <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o      = (r_state == ARB_IDLE) ? w_grant : '0;
  assign bus.resp_valid_o     = w_resp_valid;
  assign bus.resp_pte_o       = r_pte;
  assign bus.resp_fault_o     = (r_state == ARB_RESP) && r_fault;
  assign bus.ptw_req_valid_o  = (r_state == ARB_ISSUE);
  assign bus.ptw_req_vpn_o    = r_vpn;
  assign bus.ptw_resp_ready_o = (r_state == ARB_WAIT) || (r_state == ARB_DRAIN);
  assign bus.owner_o          = r_owner;
  assign bus.busy_o           = (r_state != ARB_IDLE);
  assign bus.timeout_o        = r_timeout;

endmodule
`default_nettype wire
